// File: rtl/mlp_cardio_if.sv
// Feature, coefficient and class bundle between the capture logic, the
// Cardio MLP classifier and the class consumer.
interface mlp_cardio_if #(
    parameter int NUM_A    = 21,
    parameter int WIDTH_A  = 4,
    parameter int NUM_H    = 3,
    parameter int NUM_O    = 3,
    parameter int WIDTH_W  = 8,
    parameter int NUM_W    = 72,
    parameter int WIDTH_B0 = 12,
    parameter int WIDTH_B1 = 13,
    parameter int OUTWIDTH = 2
);
    logic [NUM_A*WIDTH_A-1:0]                  inp;
    logic [NUM_W*WIDTH_W-1:0]                  weights;
    logic [NUM_H*WIDTH_B0+NUM_O*WIDTH_B1-1:0]  biases;
    logic [OUTWIDTH-1:0]                       out;

    modport master (output inp, output weights, output biases, input out);
    modport slave  (input inp, input weights, input biases, output out);
endinterface

// File: rtl/mlp_cardio_classifier.sv
// Quantized 21-3-3 MLP for the Cardio classifier: combinational ReLU hidden
// layer, linear output layer and argmax, with a registered class index.
module mlp_cardio_classifier #(
    parameter int NUM_A    = 21,
    parameter int WIDTH_A  = 4,
    parameter int NUM_H    = 3,
    parameter int NUM_O    = 3,
    parameter int WIDTH_W  = 8,
    parameter int NUM_W    = 72,
    parameter int WIDTH_B0 = 12,
    parameter int WIDTH_B1 = 13,
    parameter int OUTWIDTH = 2
) (
    input logic         clk,
    input logic         rst,
    mlp_cardio_if.slave bus
);
    // Widths are sized so the worst-case sums are exact (|acc| <= 42368).
    localparam int ACC_W   = 18;
    localparam int H_W     = 16;
    localparam int SCORE_W = 26;
    localparam int L2_BASE = NUM_A * NUM_H;
    localparam int B1_BASE = NUM_H * WIDTH_B0;

    logic signed [ACC_W-1:0]   acc_s   [NUM_H];
    logic        [H_W-1:0]     h_s     [NUM_H];
    logic signed [SCORE_W-1:0] score_s [NUM_O];
    logic signed [ACC_W-1:0]   w1_ext_s;
    logic signed [ACC_W-1:0]   x_ext_s;
    logic signed [SCORE_W-1:0] w2_ext_s;
    logic signed [SCORE_W-1:0] h_ext_s;
    logic signed [SCORE_W-1:0] best_s;
    logic        [OUTWIDTH-1:0] class_s;
    logic        [OUTWIDTH-1:0] out_r;

    // Hidden layer: biased dot product of unsigned features, then ReLU.
    always_comb begin
        w1_ext_s = '0;
        x_ext_s  = '0;
        for (int j = 0; j < NUM_H; j++) begin
            acc_s[j] = ACC_W'($signed(bus.biases[WIDTH_B0*j +: WIDTH_B0]));
            for (int i = 0; i < NUM_A; i++) begin
                w1_ext_s = ACC_W'($signed(bus.weights[WIDTH_W*(j*NUM_A+i) +: WIDTH_W]));
                x_ext_s  = ACC_W'(bus.inp[WIDTH_A*i +: WIDTH_A]);
                acc_s[j] = acc_s[j] + w1_ext_s * x_ext_s;
            end
            if (acc_s[j][ACC_W-1]) begin
                h_s[j] = 16'd0;
            end else begin
                h_s[j] = acc_s[j][H_W-1:0];
            end
        end
    end

    // Output layer: biased linear combination of the hidden activations.
    always_comb begin
        w2_ext_s = '0;
        h_ext_s  = '0;
        for (int k = 0; k < NUM_O; k++) begin
            score_s[k] = SCORE_W'($signed(bus.biases[B1_BASE+WIDTH_B1*k +: WIDTH_B1]));
            for (int j = 0; j < NUM_H; j++) begin
                w2_ext_s   = SCORE_W'($signed(bus.weights[WIDTH_W*(L2_BASE+NUM_H*k+j) +: WIDTH_W]));
                h_ext_s    = SCORE_W'(h_s[j]);
                score_s[k] = score_s[k] + w2_ext_s * h_ext_s;
            end
        end
    end

    // Argmax; strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_s  = score_s[0];
        class_s = 2'd0;
        for (int k = 1; k < NUM_O; k++) begin
            if (score_s[k] > best_s) begin
                best_s  = score_s[k];
                class_s = OUTWIDTH'(k);
            end else begin
                best_s  = best_s;
                class_s = class_s;
            end
        end
    end

    // Class register: one-cycle latency, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r <= 2'd0;
        end else begin
            out_r <= class_s;
        end
    end

    assign bus.out = out_r;
endmodule

// File: tb/tb_mlp_cardio_classifier.sv
// Self-checking bench for mlp_cardio_classifier: directed coefficient sets
// plus randomized vectors against an integer reference model.
module tb_mlp_cardio_classifier;
    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    int x  [21];
    int w  [72];
    int b0 [3];
    int b1 [3];

    mlp_cardio_if bus ();

    mlp_cardio_classifier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic straight from the layer equations.
    function automatic int ref_class();
        int h [3];
        int s [3];
        int acc;
        int best;
        for (int j = 0; j < 3; j++) begin
            acc = b0[j];
            for (int i = 0; i < 21; i++) acc += w[j*21+i] * x[i];
            h[j] = (acc < 0) ? 0 : acc;
        end
        for (int k = 0; k < 3; k++) begin
            s[k] = b1[k];
            for (int j = 0; j < 3; j++) s[k] += w[63+3*k+j] * h[j];
        end
        best = 0;
        for (int k = 1; k < 3; k++) if (s[k] > s[best]) best = k;
        return best;
    endfunction

    task automatic clear_model();
        foreach (x[i])  x[i]  = 0;
        foreach (w[i])  w[i]  = 0;
        foreach (b0[i]) b0[i] = 0;
        foreach (b1[i]) b1[i] = 0;
    endtask

    task automatic drive_model();
        for (int i = 0; i < 21; i++) bus.inp[4*i +: 4]          = x[i][3:0];
        for (int m = 0; m < 72; m++) bus.weights[8*m +: 8]      = w[m][7:0];
        for (int j = 0; j < 3; j++)  bus.biases[12*j +: 12]     = b0[j][11:0];
        for (int k = 0; k < 3; k++)  bus.biases[36+13*k +: 13]  = b1[k][12:0];
    endtask

    // Applies the model state at a falling edge and samples after the next rise.
    task automatic apply_and_check(input string name, input int expected);
        @(negedge clk);
        drive_model();
        @(posedge clk);
        #1;
        vectors++;
        if (bus.out !== expected[1:0]) begin
            errors++;
            $display("FAIL %s: out=%0d expected=%0d", name, bus.out, expected);
        end
    endtask

    task automatic set_deployed();
        int l2 [9];
        l2 = '{-7, -45, 28, 6, -21, -22, 5, 95, -52};
        clear_model();
        for (int m = 0; m < 63; m++) w[m] = $urandom_range(255) - 128;
        for (int m = 0; m < 9; m++)  w[63+m] = l2[m];
        b0[0] = -73;   b0[1] = 748; b0[2] = 1077;
        b1[0] = -1547; b1[1] = 902; b1[2] = -2131;
    endtask

    task automatic test_reset();
        clear_model();
        drive_model();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.out !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: out=%0d expected=0", bus.out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_deployed();
        set_deployed();
        apply_and_check("deployed_zero_inputs", 2);
        vectors++;
        if (ref_class() !== 2) begin
            errors++;
            $display("FAIL deployed_model: model=%0d expected=2", ref_class());
        end
    endtask

    task automatic test_ties();
        clear_model();
        for (int i = 0; i < 21; i++) x[i] = $urandom_range(15);
        apply_and_check("three_way_tie", 0);
        clear_model();
        b1[0] = 100; b1[1] = 500; b1[2] = 500;
        apply_and_check("tie_1_2", 1);
    endtask

    task automatic test_relu();
        clear_model();
        for (int i = 0; i < 21; i++) x[i] = $urandom_range(15);
        b0[0] = -1; b0[1] = -2048; b0[2] = 5;
        w[63+3*2+0] = 127;
        w[63+3*1+2] = 1;
        apply_and_check("relu_clamp", 1);
    endtask

    task automatic test_extreme();
        clear_model();
        for (int i = 0; i < 21; i++) x[i] = 15;
        for (int m = 0; m < 63; m++) w[m] = 127;
        for (int j = 0; j < 3; j++)  b0[j] = 2047;
        w[63] = -128;
        apply_and_check("extreme_no_saturation", 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < 21; i++) x[i]  = $urandom_range(15);
            for (int m = 0; m < 72; m++) w[m]  = $urandom_range(255) - 128;
            for (int j = 0; j < 3; j++)  b0[j] = $urandom_range(4095) - 2048;
            for (int k = 0; k < 3; k++)  b1[k] = $urandom_range(8191) - 4096;
            apply_and_check("random", ref_class());
        end
    endtask

    // Small coefficient ranges make score ties frequent.
    task automatic test_back_to_back();
        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < 21; i++) x[i]  = $urandom_range(3);
            for (int m = 0; m < 72; m++) w[m]  = $urandom_range(2) - 1;
            for (int j = 0; j < 3; j++)  b0[j] = $urandom_range(4) - 2;
            for (int k = 0; k < 3; k++)  b1[k] = $urandom_range(2) - 1;
            apply_and_check("back_to_back_tie_prone", ref_class());
        end
    endtask

    task automatic test_async_reset();
        set_deployed();
        apply_and_check("pre_reset_class", 2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.out !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_immediate: out=%0d expected=0", bus.out);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.out !== 2'd0) begin
            errors++;
            $display("FAIL reset_held: out=%0d expected=0", bus.out);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.out !== 2'd0) begin
            errors++;
            $display("FAIL release_before_edge: out=%0d expected=0", bus.out);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.out !== 2'd2) begin
            errors++;
            $display("FAIL first_edge_after_release: out=%0d expected=2", bus.out);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.inp     = '0;
        bus.weights = '0;
        bus.biases  = '0;
        test_reset();
        test_deployed();
        test_ties();
        test_relu();
        test_extreme();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mlp_cardio_classifier.md
Name: mlp_cardio_classifier

Overview:
- Fixed-topology quantized MLP inference block for the 3-class Cardio classifier: 21 unsigned 4-bit features, 3 ReLU hidden neurons, 3 linear output neurons, argmax class index.
- Weights and biases arrive on flat ports, not in internal ROM, so coefficient sets can be changed without re-synthesis.
- Combinational datapath with a registered class output; sits between the feature-capture logic and the class consumer.

Parameters:
- NUM_A, 21, number of input features.
- WIDTH_A, 4, feature width (unsigned).
- NUM_H, 3, hidden neurons.
- NUM_O, 3, output neurons / classes.
- WIDTH_W, 8, weight width (signed two's complement).
- NUM_W, 72, total weights (NUM_A*NUM_H + NUM_H*NUM_O).
- WIDTH_B0, 12, hidden bias width (signed).
- WIDTH_B1, 13, output bias width (signed).
- OUTWIDTH, 2, class index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- inp  input  84  features; feature i = inp[4i+3:4i].
- weights  input  576  weight slot m = weights[8m+7:8m], signed.
- biases  input  75  hidden bias j = biases[12j+11:12j]; output bias k = biases[36+13k+12:36+13k]; all signed.
- out  output  2  registered argmax class index (0..2).

Behaviour:
- Layer-1 weight (hidden j, input i) is slot j*21+i (slots 0..62).
- Layer-2 weight (output k, hidden j) is slot 63+3k+j (slots 63..71).
- Hidden accumulator: acc_j = sext(b0_j) + sum_i w(j,i)*zext(x_i).
  - Computed at 18-bit signed; the worst case |acc| ≤ 42368 fits, so no overflow or saturation logic is needed.
- Hidden activation: h_j = ReLU(acc_j).
  - Negative gives 0; otherwise the full value is kept as 16-bit unsigned.
  - No shift or truncation.
- Output score: s_k = sext(b1_k) + sum_j w(k,j)*h_j.
  - Computed at 26-bit signed; exact, no overflow possible.
- Class: index of the maximum s_k under signed compare.
  - On ties the lowest index wins: s0 = s1 = s2 gives 0; s1 = s2 > s0 gives 1.
- Latency: out is registered. It is updated on every rising clk edge with the class of the inputs present during that cycle.
  - One-cycle latency; no handshake.
  - inp, weights and biases must be stable for the setup window before the edge.
- Reset: rst = 1 forces out = 0 immediately, independent of clk.
  - out holds 0 while rst is high.
  - The first edge after release loads the class of the current inputs.
  - Reset asserted mid-stream discards the pending result.
- The value 3 never appears on out.
- No other state exists; the datapath is purely combinational up to the out register.

Test Plan:
- Deployed Cardio coefficient set, all inputs 0:
  - Hidden biases (slot 0..2) = -73, 748, 1077; output biases = -1547, 902, -2131.
  - Layer-2 slots 63..71 = -7, -45, 28, 6, -21, -22, 5, 95, -52.
  - Required: h = (0, 748, 1077), s = (-5051, -38500, 12925), out = 2 one edge after the input is applied.
- All weights and biases 0, any inputs -> out = 0 (three-way tie resolves to the lowest index).
- All weights 0; output biases 100, 500, 500 -> out = 1 (tie between 1 and 2 resolves to the lower index).
- ReLU check: all layer-1 weights 0; hidden biases -1, -2048, 5; layer-2 weights all 0 except slot 63+3*2+0 = 127 and slot 63+3*1+2 = 1; output biases 0.
  - Required: h = (0, 0, 5), s = (0, 5, 0), out = 1.
  - Proves the negative hidden neuron is clamped, not passed through.
- Saturation-free extreme: all x = 15, all layer-1 weights = 127, hidden biases = 2047, layer-2 weight slot 63 = -128, others 0, output biases 0.
  - Required: h0 = 42052, s0 = -5382656, out = 1.
  - Tie of s1 = s2 = 0 resolves to the lower index.
- Reset: drive inputs giving class 2, assert rst asynchronously between edges -> out = 0 immediately and held while rst is high.
  - Release rst -> out = 2 after the next rising edge.
